// File: rtl/pic_pkg.sv
// Shared 8259 definitions: acknowledge-sequence states, fixed opcode bytes
// and the one-hot to index helper.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK1 = 2'b01,
    ACK2 = 2'b10,
    ACK3 = 2'b11
  } control_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [7:0] SPURIOUS_IR = 8'h80;

  function automatic logic [2:0] bit2num(input logic [7:0] onehot);
    logic [2:0] num;
    num = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) num = num | 3'(i);
    end
    return num;
  endfunction

endpackage

// File: rtl/inta_edge_detector.sv
// Registers the previous INTA sample and flags falling/rising edges of the
// already-synchronised pin.
module inta_edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic abort_i,
  input  logic inta_n_i,
  output logic fall_o,
  output logic rise_o
);

  logic inta_q;
  logic armed_q;

  // A pin already low when reset or abort lifts must not look like a new
  // acknowledge; falls are only honoured after the pin has been seen high.
  always_ff @(posedge clock) begin
    if (!reset_n || abort_i) begin
      inta_q  <= 1'b1;
      armed_q <= inta_n_i;
    end else begin
      inta_q <= inta_n_i;
      if (inta_n_i) armed_q <= 1'b1;
    end
  end

  assign fall_o = armed_q & inta_q & ~inta_n_i;
  assign rise_o = ~inta_q & inta_n_i;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA-cycle controller: steps through the 8080/8086 acknowledge sequence,
// pulses ISR set/clear and drives the vector or CALL bytes.
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int VECTOR_BITS = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   interrupt_acknowledge_n,
  input  logic                   write_initial_command_word_1,
  input  logic                   interrupt_pending,
  input  logic [VECTOR_BITS-1:0] highest_priority_onehot,
  input  logic                   u8086_mode_config,
  input  logic                   auto_eoi_config,
  input  logic [4:0]             vector_base_config,
  input  logic [VECTOR_BITS-1:0] call_address_low_config,
  input  logic [VECTOR_BITS-1:0] call_address_high_config,
  input  logic                   cascade_slave,
  input  logic                   cascade_output_ack_2,
  output logic                   interrupt_to_cpu,
  output logic [1:0]             control_state,
  output logic [VECTOR_BITS-1:0] acknowledge_interrupt,
  output logic [VECTOR_BITS-1:0] in_service_set,
  output logic [VECTOR_BITS-1:0] in_service_clear,
  output logic                   end_of_acknowledge,
  output logic                   out_control_logic_data,
  output logic [VECTOR_BITS-1:0] control_logic_data
);

  logic fall;
  logic rise;

  control_state_t         state_q;
  logic [VECTOR_BITS-1:0] ack_q;
  logic [VECTOR_BITS-1:0] set_q;
  logic [VECTOR_BITS-1:0] clr_q;
  logic [VECTOR_BITS-1:0] data_q;
  logic                   int_q;
  logic                   eoa_q;
  logic                   oe_q;
  logic                   spurious_q;

  logic [VECTOR_BITS-1:0] ack_d;
  logic [VECTOR_BITS-1:0] ack2_byte_d;
  logic                   call_drive_d;
  logic                   seq_end_d;

  inta_edge_detector u_edge (
    .clock    (clock),
    .reset_n  (reset_n),
    .abort_i  (write_initial_command_word_1),
    .inta_n_i (interrupt_acknowledge_n),
    .fall_o   (fall),
    .rise_o   (rise)
  );

  assign ack_d        = (highest_priority_onehot == '0) ? SPURIOUS_IR : highest_priority_onehot;
  assign ack2_byte_d  = u8086_mode_config ? {vector_base_config, bit2num(ack_q)}
                                          : call_address_low_config;
  assign call_drive_d = ~u8086_mode_config & ~cascade_slave;
  assign seq_end_d    = rise & (((state_q == ACK2) & u8086_mode_config) | (state_q == ACK3));

  always_ff @(posedge clock) begin
    if (!reset_n || write_initial_command_word_1) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      set_q      <= '0;
      clr_q      <= '0;
      data_q     <= '0;
      int_q      <= 1'b0;
      eoa_q      <= 1'b0;
      oe_q       <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      set_q <= '0;
      clr_q <= '0;
      eoa_q <= 1'b0;
      int_q <= 1'b0;
      if (seq_end_d) begin
        state_q    <= IDLE;
        eoa_q      <= 1'b1;
        clr_q      <= (auto_eoi_config && !spurious_q) ? ack_q : '0;
        ack_q      <= '0;
        spurious_q <= 1'b0;
        oe_q       <= 1'b0;
        data_q     <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            int_q <= interrupt_pending;
            if (fall) begin
              state_q    <= ACK1;
              ack_q      <= ack_d;
              spurious_q <= (highest_priority_onehot == '0);
              set_q      <= highest_priority_onehot;
              int_q      <= 1'b0;
              oe_q       <= call_drive_d;
              data_q     <= call_drive_d ? CALL_OPCODE : '0;
            end
          end
          ACK1: begin
            if (fall) begin
              state_q <= ACK2;
              oe_q    <= cascade_output_ack_2;
              data_q  <= cascade_output_ack_2 ? ack2_byte_d : '0;
            end else if (rise) begin
              oe_q   <= 1'b0;
              data_q <= '0;
            end
          end
          ACK2: begin
            // Only the 8080 path gets here on a rise; 8086 ends via seq_end_d.
            if (rise) begin
              oe_q   <= 1'b0;
              data_q <= '0;
            end else if (fall && !u8086_mode_config) begin
              state_q <= ACK3;
              oe_q    <= cascade_output_ack_2;
              data_q  <= cascade_output_ack_2 ? call_address_high_config : '0;
            end
          end
          ACK3: begin
          end
        endcase
      end
    end
  end

  assign interrupt_to_cpu       = int_q;
  assign control_state          = state_q;
  assign acknowledge_interrupt  = ack_q;
  assign in_service_set         = set_q;
  assign in_service_clear       = clr_q;
  assign end_of_acknowledge     = eoa_q;
  assign out_control_logic_data = oe_q;
  assign control_logic_data     = data_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: scenario tasks plus a
// scoreboard of expected driven bytes and ISR set/clear pulses.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       inta_n = 1'b1;
  logic       icw1 = 1'b0;
  logic       pending = 1'b0;
  logic [7:0] hpo = 8'h00;
  logic       mode86 = 1'b1;
  logic       aeoi = 1'b0;
  logic [4:0] base = 5'b00000;
  logic [7:0] callLow = 8'h00;
  logic [7:0] callHigh = 8'h00;
  logic       slave = 1'b0;
  logic       cao2 = 1'b1;

  logic       intToCpu;
  logic [1:0] ctlState;
  logic [7:0] ackIr;
  logic [7:0] isrSet;
  logic [7:0] isrClr;
  logic       eoa;
  logic       oe;
  logic [7:0] dataByte;

  int total = 0;
  int bad = 0;

  logic [7:0] byteQ[$];
  logic [7:0] setQ[$];
  logic [7:0] clrQ[$];
  logic       oePrev = 1'b0;
  logic [7:0] expByte;

  interrupt_ack_sequencer #(.VECTOR_BITS(8)) dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .interrupt_acknowledge_n      (inta_n),
    .write_initial_command_word_1 (icw1),
    .interrupt_pending            (pending),
    .highest_priority_onehot      (hpo),
    .u8086_mode_config            (mode86),
    .auto_eoi_config              (aeoi),
    .vector_base_config           (base),
    .call_address_low_config      (callLow),
    .call_address_high_config     (callHigh),
    .cascade_slave                (slave),
    .cascade_output_ack_2         (cao2),
    .interrupt_to_cpu             (intToCpu),
    .control_state                (ctlState),
    .acknowledge_interrupt        (ackIr),
    .in_service_set               (isrSet),
    .in_service_clear             (isrClr),
    .end_of_acknowledge           (eoa),
    .out_control_logic_data       (oe),
    .control_logic_data           (dataByte)
  );

  always #5 clock = ~clock;

  // Scoreboard: each new drive window and each ISR pulse consumes one entry.
  always @(negedge clock) begin
    if (oe === 1'b1 && oePrev !== 1'b1) begin
      total++;
      if (byteQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL drive_unexpected: got byte %h, expected no drive", dataByte);
      end else begin
        expByte = byteQ.pop_front();
        if (dataByte !== expByte) begin
          bad++;
          $display("[TB] FAIL drive_byte: got %h expected %h", dataByte, expByte);
        end
      end
    end
    oePrev = oe;
    if (isrSet !== 8'h00 && reset_n === 1'b1) begin
      total++;
      if (setQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL isr_set_unexpected: got %h expected 00", isrSet);
      end else begin
        expByte = setQ.pop_front();
        if (isrSet !== expByte) begin
          bad++;
          $display("[TB] FAIL isr_set: got %h expected %h", isrSet, expByte);
        end
      end
    end
    if (isrClr !== 8'h00 && reset_n === 1'b1) begin
      total++;
      if (clrQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL isr_clear_unexpected: got %h expected 00", isrClr);
      end else begin
        expByte = clrQ.pop_front();
        if (isrClr !== expByte) begin
          bad++;
          $display("[TB] FAIL isr_clear: got %h expected %h", isrClr, expByte);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    chk("reset_state", {6'd0, ctlState}, 8'h00);
    chk("reset_ack", ackIr, 8'h00);
    chk("reset_oe", {7'd0, oe}, 8'h00);
    chk("reset_int", {7'd0, intToCpu}, 8'h00);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_8086_vector;
    mode86 = 1'b1; aeoi = 1'b0; base = 5'b01000; hpo = 8'h08; pending = 1'b1;
    slave = 1'b0; cao2 = 1'b1;
    tick(2);
    chk("int_to_cpu_idle", {7'd0, intToCpu}, 8'h01);
    setQ.push_back(8'h08);
    byteQ.push_back(8'h43);
    inta_n = 1'b0; tick(1);
    chk("8086_ack1_state", {6'd0, ctlState}, 8'h01);
    chk("8086_ack_latch", ackIr, 8'h08);
    chk("8086_int_cleared", {7'd0, intToCpu}, 8'h00);
    chk("8086_ack1_no_drive", {7'd0, oe}, 8'h00);
    pending = 1'b0; hpo = 8'h00;
    tick(1); inta_n = 1'b1; tick(2);
    chk("8086_ack1_hold", {6'd0, ctlState}, 8'h01);
    inta_n = 1'b0; tick(1);
    chk("8086_ack2_state", {6'd0, ctlState}, 8'h02);
    chk("8086_ack2_oe", {7'd0, oe}, 8'h01);
    tick(1); inta_n = 1'b1; tick(1);
    chk("8086_end_state", {6'd0, ctlState}, 8'h00);
    chk("8086_eoa", {7'd0, eoa}, 8'h01);
    chk("8086_ack_cleared", ackIr, 8'h00);
    tick(1);
    chk("8086_eoa_one_cycle", {7'd0, eoa}, 8'h00);
    tick(1);
  endtask

  task automatic test_8080_call;
    mode86 = 1'b0; aeoi = 1'b1; hpo = 8'h20; callLow = 8'h54; callHigh = 8'h12;
    byteQ.push_back(8'hCD);
    byteQ.push_back(8'h54);
    byteQ.push_back(8'h12);
    setQ.push_back(8'h20);
    clrQ.push_back(8'h20);
    inta_n = 1'b0; tick(1);
    chk("8080_ack1_state", {6'd0, ctlState}, 8'h01);
    chk("8080_opcode", dataByte, 8'hCD);
    tick(1); inta_n = 1'b1; tick(1);
    chk("8080_ack1_oe_drop", {7'd0, oe}, 8'h00);
    chk("8080_ack1_hold", {6'd0, ctlState}, 8'h01);
    tick(1); inta_n = 1'b0; tick(1);
    chk("8080_ack2_state", {6'd0, ctlState}, 8'h02);
    tick(1); inta_n = 1'b1; tick(1);
    chk("8080_ack2_hold", {6'd0, ctlState}, 8'h02);
    tick(1); inta_n = 1'b0; tick(1);
    chk("8080_ack3_state", {6'd0, ctlState}, 8'h03);
    chk("8080_high_byte", dataByte, 8'h12);
    tick(1); inta_n = 1'b1; tick(1);
    chk("8080_end_state", {6'd0, ctlState}, 8'h00);
    chk("8080_eoa", {7'd0, eoa}, 8'h01);
    chk("8080_aeoi_clear", isrClr, 8'h20);
    hpo = 8'h00;
    tick(2);
  endtask

  task automatic test_spurious;
    mode86 = 1'b1; aeoi = 1'b1; base = 5'b10101; hpo = 8'h00;
    byteQ.push_back(8'hAF);
    inta_n = 1'b0; tick(1);
    chk("spur_ack", ackIr, 8'h80);
    chk("spur_no_set", isrSet, 8'h00);
    tick(1); inta_n = 1'b1; tick(2);
    inta_n = 1'b0; tick(1);
    chk("spur_vector", dataByte, 8'hAF);
    tick(1); inta_n = 1'b1; tick(1);
    chk("spur_eoa", {7'd0, eoa}, 8'h01);
    chk("spur_no_clear", isrClr, 8'h00);
    tick(2);
  endtask

  task automatic test_slave_gated;
    mode86 = 1'b1; aeoi = 1'b0; slave = 1'b1; cao2 = 1'b0; hpo = 8'h02;
    setQ.push_back(8'h02);
    inta_n = 1'b0; tick(1);
    chk("slave_ack1_oe", {7'd0, oe}, 8'h00);
    tick(1); inta_n = 1'b1; tick(2);
    inta_n = 1'b0; tick(1);
    chk("slave_ack2_state", {6'd0, ctlState}, 8'h02);
    chk("slave_ack2_oe", {7'd0, oe}, 8'h00);
    tick(1); inta_n = 1'b1; tick(1);
    chk("slave_eoa", {7'd0, eoa}, 8'h01);
    slave = 1'b0; cao2 = 1'b1; hpo = 8'h00;
    tick(2);
  endtask

  task automatic test_icw1_abort;
    mode86 = 1'b1; aeoi = 1'b0; base = 5'b00001; hpo = 8'h04;
    setQ.push_back(8'h04);
    byteQ.push_back(8'h0A);
    inta_n = 1'b0; tick(1);
    tick(1); inta_n = 1'b1; tick(1);
    inta_n = 1'b0; tick(1);
    chk("icw1_pre_state", {6'd0, ctlState}, 8'h02);
    icw1 = 1'b1; tick(1); icw1 = 1'b0;
    chk("icw1_state", {6'd0, ctlState}, 8'h00);
    chk("icw1_ack", ackIr, 8'h00);
    chk("icw1_no_eoa", {7'd0, eoa}, 8'h00);
    chk("icw1_oe", {7'd0, oe}, 8'h00);
    tick(2);
    chk("icw1_low_no_restart", {6'd0, ctlState}, 8'h00);
    inta_n = 1'b1; tick(2);
    chk("icw1_still_no_eoa", {7'd0, eoa}, 8'h00);
    setQ.push_back(8'h04);
    byteQ.push_back(8'h0A);
    inta_n = 1'b0; tick(1);
    chk("icw1_restart_ack1", {6'd0, ctlState}, 8'h01);
    chk("icw1_restart_latch", ackIr, 8'h04);
    tick(1); inta_n = 1'b1; tick(1);
    inta_n = 1'b0; tick(2);
    inta_n = 1'b1; tick(1);
    chk("icw1_restart_eoa", {7'd0, eoa}, 8'h01);
    hpo = 8'h00;
    tick(2);
  endtask

  task automatic test_reset_mid_ack1;
    mode86 = 1'b0; aeoi = 1'b0; slave = 1'b0; hpo = 8'h01; pending = 1'b0;
    setQ.push_back(8'h01);
    byteQ.push_back(8'hCD);
    inta_n = 1'b0; tick(1);
    chk("rst_ack1_oe", {7'd0, oe}, 8'h01);
    tick(1);
    reset_n = 1'b0; tick(1);
    chk("rst_state", {6'd0, ctlState}, 8'h00);
    chk("rst_ack", ackIr, 8'h00);
    chk("rst_oe", {7'd0, oe}, 8'h00);
    chk("rst_data", dataByte, 8'h00);
    chk("rst_set", isrSet, 8'h00);
    chk("rst_eoa", {7'd0, eoa}, 8'h00);
    tick(1);
    reset_n = 1'b1; tick(3);
    chk("rst_low_no_fall", {6'd0, ctlState}, 8'h00);
    inta_n = 1'b1; tick(2);
    chk("rst_idle_after", {6'd0, ctlState}, 8'h00);
    hpo = 8'h00;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_8086_vector();
    test_8080_call();
    test_spurious();
    test_slave_gated();
    test_icw1_abort();
    test_reset_mid_ack1();
    tick(2);
    chk("leftover_bytes", 8'(byteQ.size()), 8'h00);
    chk("leftover_sets", 8'(setQ.size()), 8'h00);
    chk("leftover_clears", 8'(clrQ.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
